// File: rtl/temp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : temp_pkg
// Description : Shared types and constants for the temperature-to-BCD
//               converter: FSM state encoding, double-dabble iteration
//               count, BCD field widths and the 1/16 degC fraction scale.
// Revision    : 1.0 - initial release
// ============================================================================
package temp_pkg;

    // Conversion sequencer states
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ABS  = 2'd1,
        S_CONV = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // Width of both binary source shift registers (fraction max is 9375)
    localparam int SRC_W = 14;

    // Number of double-dabble shift iterations, one per source bit
    localparam int DD_ITER = SRC_W;

    // Last value of the 4-bit iteration counter
    localparam logic [3:0] CNT_LAST = 4'(DD_ITER - 1);

    // BCD accumulator sizes: hundreds/tens/units and four fraction digits
    localparam int INT_NIBBLES  = 3;
    localparam int FRAC_NIBBLES = 4;
    localparam int INT_BCD_W    = 4 * INT_NIBBLES;
    localparam int FRAC_BCD_W   = 4 * FRAC_NIBBLES;

    // One LSB of the fraction is 0.0625 degC = 625 x 10^-4
    localparam logic [SRC_W-1:0] FRAC_SCALE = 14'd625;

endpackage : temp_pkg
`default_nettype wire

// File: rtl/bcd_dd_step.sv
`default_nettype none
// ============================================================================
// Module      : bcd_dd_step
// Description : One combinational double-dabble step for an N-nibble BCD
//               accumulator: add 3 to every nibble >= 5, then shift left by
//               one bit, inserting bit_in at the LSB.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_dd_step #(
    parameter int NIBBLES = 3
) (
    input  logic [4*NIBBLES-1:0] acc_in,
    input  logic                 bit_in,
    output logic [4*NIBBLES-1:0] acc_out
);

    logic [4*NIBBLES-1:0] w_adj;

    // Per-nibble add-3 correction ahead of the shift
    for (genvar i = 0; i < NIBBLES; i++) begin : g_nib
        assign w_adj[4*i +: 4] = (acc_in[4*i +: 4] >= 4'd5) ? (acc_in[4*i +: 4] + 4'd3)
                                                            : acc_in[4*i +: 4];
    end

    // The corrected MSB falls off the top; with valid input ranges it is zero
    logic w_unused_msb;
    assign w_unused_msb = w_adj[4*NIBBLES-1];

    assign acc_out = {w_adj[4*NIBBLES-2:0], bit_in};

endmodule : bcd_dd_step
`default_nettype wire

// File: rtl/temp_bcd_conv.sv
`default_nettype none
// ============================================================================
// Module      : temp_bcd_conv
// Description : Converts a 16-bit two's-complement temperature sample
//               (1/16 degC per LSB) into a sign flag and packed BCD digits
//               (hundreds.units + four fraction digits) by iterative
//               double-dabble. Fixed 16-cycle latency from din_vld to
//               dout_vld.
//               Build option TEMP_CLAMP_EN: clamp the magnitude to
//               CLAMP_HI (positive) / CLAMP_LO (negative) integer degC.
// Revision    : 1.0 - initial release
// ============================================================================
module temp_bcd_conv
    import temp_pkg::*;
#(
    parameter int CLAMP_HI = 125,
    parameter int CLAMP_LO = 55
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] din,
    input  logic        din_vld,
    output logic        busy,
    output logic        dout_sign,
    output logic [31:0] dout,
    output logic        dout_vld
);

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [15:0]            r_din;
    logic                   r_sign;
    logic [3:0]             r_cnt;
    logic [SRC_W-1:0]       r_int_src;
    logic [SRC_W-1:0]       r_frac_src;
    logic [INT_BCD_W-1:0]   r_int_acc;
    logic [FRAC_BCD_W-1:0]  r_frac_acc;
    logic [INT_BCD_W-1:0]   w_int_acc_nxt;
    logic [FRAC_BCD_W-1:0]  w_frac_acc_nxt;
    logic [15:0]            w_mag;
    logic [15:0]            w_mag_lim;
    logic [SRC_W-1:0]       w_int_bin;
    logic [SRC_W-1:0]       w_frac_bin;
    logic [31:0]            w_result;

    // Magnitude of the captured sample; 0x8000 wraps to itself
    assign w_mag = r_din[15] ? (~r_din + 16'd1) : r_din;

`ifdef TEMP_CLAMP_EN
    localparam logic [15:0] C_LIM_HI = 16'(CLAMP_HI * 16);
    localparam logic [15:0] C_LIM_LO = 16'(CLAMP_LO * 16);

    // Saturate the magnitude to the sign-dependent limit
    always_comb begin
        w_mag_lim = w_mag;
        if (!r_din[15] && (w_mag > C_LIM_HI)) begin
            w_mag_lim = C_LIM_HI;
        end else if (r_din[15] && (w_mag > C_LIM_LO)) begin
            w_mag_lim = C_LIM_LO;
        end
    end
`else
    assign w_mag_lim = w_mag;

    // Clamp limits only matter when the clamp option is built in
    logic w_unused_clamp;
    assign w_unused_clamp = &{1'b0, CLAMP_HI[0], CLAMP_LO[0]};
`endif

    // Magnitude bits above the 7-bit integer field never reach the output
    logic w_unused_mag;
    assign w_unused_mag = &{1'b0, w_mag_lim[15:11]};

    assign w_int_bin  = {7'd0, w_mag_lim[10:4]};
    assign w_frac_bin = {10'd0, w_mag_lim[3:0]} * FRAC_SCALE;
    assign w_result   = {4'h0, r_int_acc, r_frac_acc};

    // Integer and fraction accumulators advance in lock-step
    bcd_dd_step #(.NIBBLES(INT_NIBBLES)) u_int_step (
        .acc_in  (r_int_acc),
        .bit_in  (r_int_src[SRC_W-1]),
        .acc_out (w_int_acc_nxt)
    );

    bcd_dd_step #(.NIBBLES(FRAC_NIBBLES)) u_frac_step (
        .acc_in  (r_frac_acc),
        .bit_in  (r_frac_src[SRC_W-1]),
        .acc_out (w_frac_acc_nxt)
    );

    // Busy spans ABS, CONV and DONE
    assign busy = (r_state != S_IDLE);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; DONE also accepts a new sample so back-to-back
    // conversions run at one per 16 cycles
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (din_vld) w_state_nxt = S_ABS;
            S_ABS:  w_state_nxt = S_CONV;
            S_CONV: if (r_cnt == CNT_LAST) w_state_nxt = S_DONE;
            S_DONE: w_state_nxt = din_vld ? S_ABS : S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Datapath: capture, load, iterate and publish the result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_din      <= 16'h0;
            r_sign     <= 1'b0;
            r_cnt      <= 4'd0;
            r_int_src  <= '0;
            r_frac_src <= '0;
            r_int_acc  <= '0;
            r_frac_acc <= '0;
            dout       <= 32'h0;
            dout_sign  <= 1'b0;
            dout_vld   <= 1'b0;
        end else begin
            dout_vld <= (r_state == S_DONE);
            case (r_state)
                S_IDLE: begin
                    if (din_vld) r_din <= din;
                end
                S_ABS: begin
                    r_sign     <= r_din[15];
                    r_int_src  <= w_int_bin;
                    r_frac_src <= w_frac_bin;
                    r_int_acc  <= '0;
                    r_frac_acc <= '0;
                    r_cnt      <= 4'd0;
                end
                S_CONV: begin
                    r_int_acc  <= w_int_acc_nxt;
                    r_frac_acc <= w_frac_acc_nxt;
                    r_int_src  <= {r_int_src[SRC_W-2:0], 1'b0};
                    r_frac_src <= {r_frac_src[SRC_W-2:0], 1'b0};
                    r_cnt      <= r_cnt + 4'd1;
                end
                S_DONE: begin
                    dout      <= w_result;
                    // A zero result is always reported positive
                    dout_sign <= r_sign & (|w_result);
                    if (din_vld) r_din <= din;
                end
                default: ;
            endcase
        end
    end

endmodule : temp_bcd_conv
`default_nettype wire

// File: tb/tb_temp_bcd_conv.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_temp_bcd_conv
// Description : Scoreboard bench for temp_bcd_conv. A reference process
//               decides acceptance and pushes expected results with their
//               due cycle; a monitor on the falling edge compares busy,
//               dout_vld, dout and dout_sign every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_temp_bcd_conv;

    localparam int CLAMP_HI = 125;
    localparam int CLAMP_LO = 55;
    localparam int LAT      = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] din = 16'h0;
    logic        din_vld = 1'b0;
    logic        busy;
    logic        dout_sign;
    logic [31:0] dout;
    logic        dout_vld;

    typedef struct {
        logic        sign;
        logic [31:0] val;
        int          due;
    } exp_t;

    exp_t        sb[$];
    int          cyc = 0;
    int          m_k = 0;
    bit          m_active = 0;
    logic        last_sign = 1'b0;
    logic [31:0] last_val = 32'h0;
    bit          dir_on = 0;
    logic [32:0] dir_exp = 33'h0;
    int          tests = 0;
    int          fails = 0;

    temp_bcd_conv #(.CLAMP_HI(CLAMP_HI), .CLAMP_LO(CLAMP_LO)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .din       (din),
        .din_vld   (din_vld),
        .busy      (busy),
        .dout_sign (dout_sign),
        .dout      (dout),
        .dout_vld  (dout_vld)
    );

    always #5 clk = ~clk;

    // Reference: temperature in 1/16 degC -> sign + decimal digits
    function automatic logic [32:0] ref_conv(input logic [15:0] d);
        int m, ip, fp;
        bit s;
        logic [31:0] v;
        s = d[15];
        m = s ? ((65536 - int'(d)) % 65536) : int'(d);
`ifdef TEMP_CLAMP_EN
        if (!s && m > CLAMP_HI * 16) m = CLAMP_HI * 16;
        if (s && m > CLAMP_LO * 16)  m = CLAMP_LO * 16;
`endif
        ip = (m / 16) % 128;
        fp = (m % 16) * 625;
        v = {4'h0, 4'(ip / 100), 4'((ip / 10) % 10), 4'(ip % 10),
             4'(fp / 1000), 4'((fp / 100) % 10), 4'((fp / 10) % 10), 4'(fp % 10)};
        return {s && (ip != 0 || fp != 0), v};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s @cycle %0d: got %h expected %h", name, cyc, got, exp);
        end
    endtask

    // Acceptance model: a sample is taken unless a conversion started
    // fewer than LAT edges ago
    always @(posedge clk) begin
        exp_t e;
        logic [32:0] r;
        cyc++;
        if (!rst_n) begin
            sb.delete();
            m_active  = 0;
            last_sign = 1'b0;
            last_val  = 32'h0;
        end else if (din_vld && (!m_active || cyc >= m_k + LAT)) begin
            r = dir_on ? dir_exp : ref_conv(din);
            e.sign = r[32];
            e.val  = r[31:0];
            e.due  = cyc + LAT;
            sb.push_back(e);
            m_k      = cyc;
            m_active = 1;
        end
    end

    // Monitor: cycle-exact handshake and held-output checks
    always @(negedge clk) begin
        bit exp_vld;
        bit exp_busy;
        exp_vld  = (sb.size() > 0) && (sb[0].due == cyc);
        exp_busy = m_active && (cyc < m_k + LAT);
        check("busy", 32'(busy), 32'(exp_busy));
        check("dout_vld", 32'(dout_vld), 32'(exp_vld));
        if (exp_vld) begin
            last_sign = sb[0].sign;
            last_val  = sb[0].val;
            void'(sb.pop_front());
        end
        check("dout", dout, last_val);
        check("dout_sign", 32'(dout_sign), 32'(last_sign));
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic send(input logic [15:0] d, input bit use_dir, input logic [32:0] e);
        din     = d;
        din_vld = 1'b1;
        dir_on  = use_dir;
        dir_exp = e;
        tick();
        din_vld = 1'b0;
        dir_on  = 0;
    endtask

    logic [15:0] dir_din [9];
    logic [32:0] dir_res [9];

    initial begin
        dir_din[0] = 16'h0191; dir_res[0] = {1'b0, 32'h00250625};
        dir_din[1] = 16'hFF5E; dir_res[1] = {1'b1, 32'h00101250};
        dir_din[2] = 16'h07D0; dir_res[2] = {1'b0, 32'h01250000};
        dir_din[3] = 16'hFC90; dir_res[3] = {1'b1, 32'h00550000};
        dir_din[4] = 16'hFFFF; dir_res[4] = {1'b1, 32'h00000625};
        dir_din[5] = 16'h0000; dir_res[5] = {1'b0, 32'h00000000};
`ifdef TEMP_CLAMP_EN
        dir_din[6] = 16'h07FF; dir_res[6] = {1'b0, 32'h01250000};
        dir_din[7] = 16'h8000; dir_res[7] = {1'b1, 32'h00550000};
`else
        dir_din[6] = 16'h07FF; dir_res[6] = {1'b0, 32'h01279375};
        dir_din[7] = 16'h8000; dir_res[7] = {1'b0, 32'h00000000};
`endif
        dir_din[8] = 16'h0008; dir_res[8] = {1'b0, 32'h00005000};

        idle(3);
        rst_n = 1'b1;
        idle(2);

        // Directed cases, spaced 16 edges apart (back-to-back acceptance)
        for (int i = 0; i < 9; i++) begin
            send(dir_din[i], 1, dir_res[i]);
            idle(LAT - 1);
        end
        idle(LAT + 4);

        // Second strobe while busy is dropped
        send(16'h0191, 1, {1'b0, 32'h00250625});
        idle(4);
        send(16'h07D0, 0, 33'h0);
        idle(LAT + 4);

        // Reset mid-conversion aborts it, then a fresh sample converts
        send(16'hFF5E, 1, {1'b1, 32'h00101250});
        idle(7);
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        idle(LAT + 4);
        send(16'hFF5E, 1, {1'b1, 32'h00101250});
        idle(LAT + 4);

        // Random sweep with random strobes, many landing while busy
        for (int i = 0; i < 20000; i++) begin
            din     = 16'($urandom);
            din_vld = ($urandom_range(0, 5) == 0);
            tick();
        end
        din_vld = 1'b0;
        idle(LAT + 8);

        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_temp_bcd_conv
`default_nettype wire
